// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: state encoding, parity sense
// and the oversampling offsets around the middle of each bit.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Sample points relative to P/2: early = P/2-1, mid = P/2, late = P/2+1,
  // and the vote is registered at P/2+2.
  localparam int SMP_EARLY = 1;
  localparam int SMP_LATE  = 1;
  localparam int SMP_VOTE  = 2;

endpackage

// File: rtl/rx_data_sampler.sv
// Three-point oversampler: captures RX at P/2-1, P/2, P/2+1 and registers the
// majority as the bit value at P/2+2, with a one-cycle ready strobe.
module rx_data_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      active,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic                      rx_in,
  output logic                      sampled_bit,
  output logic                      bit_rdy
);

  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] pt_early, pt_late, pt_vote;
  logic [2:0]                smp;
  logic                      majority;

  assign half     = prescale >> 1;
  assign pt_early = half - PRESCALE_WIDTH'(SMP_EARLY);
  assign pt_late  = half + PRESCALE_WIDTH'(SMP_LATE);
  assign pt_vote  = half + PRESCALE_WIDTH'(SMP_VOTE);
  assign majority = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smp         <= '0;
      sampled_bit <= 1'b0;
      bit_rdy     <= 1'b0;
    end else begin
      bit_rdy <= 1'b0;
      if (active) begin
        if (edge_cnt == pt_early) smp[0] <= rx_in;
        if (edge_cnt == half)     smp[1] <= rx_in;
        if (edge_cnt == pt_late)  smp[2] <= rx_in;
        if (edge_cnt == pt_vote) begin
          sampled_bit <= majority;
          bit_rdy     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, edge/bit counters, LSB-first deserializer and
// parity/stop checking; results leave as one-cycle registered pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  rx_state_t                 state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [BIT_W-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      par_en_q, par_typ_q, par_bad;
  logic                      edge_last;
  logic                      sampled_bit, bit_rdy;

  assign edge_last = (edge_cnt == prescale_q - 1'b1);

  rx_data_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .active      (state != IDLE),
    .prescale    (prescale_q),
    .edge_cnt    (edge_cnt),
    .rx_in       (RX_IN),
    .sampled_bit (sampled_bit),
    .bit_rdy     (bit_rdy)
  );

  // The FSM acts on the voted bit one cycle after the sampler registers it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_bad    <= 1'b0;
      // NOTE: the shift register is cleared too, so no stale frame bits survive reset.
      shift_q    <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != IDLE) edge_cnt <= edge_last ? '0 : edge_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (!RX_IN) begin
            state      <= START;
            edge_cnt   <= PRESCALE_WIDTH'(1);   // this cycle was edge 0
            bit_cnt    <= '0;
            prescale_q <= Prescale;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_bad    <= 1'b0;
          end
        end
        START: begin
          if (bit_rdy && sampled_bit) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (edge_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_rdy) shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (edge_last) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_rdy) par_bad <= ((^shift_q) ^ par_typ_q) != sampled_bit;
          if (edge_last) state <= STOP;
        end
        STOP: begin
          if (bit_rdy) begin
            stp_err <= ~sampled_bit;
            par_err <= par_bad;
            if (sampled_bit && !par_bad) begin
              P_DATA     <= shift_q;
              data_valid <= 1'b1;
            end
            state    <= IDLE;
            edge_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames at P=8/16/32, parity and stop
// errors, start glitch, back-to-back frames and reset mid-frame.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned start_cyc, dv_cyc, err_cyc;
  int          dv_cnt, pe_cnt, se_cnt;
  logic [7:0]  dv_q[$];

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse logger, sampled on the falling edge; one entry per high cycle.
  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_q.push_back(P_DATA);
    end
    if (par_err) pe_cnt++;
    if (stp_err) begin
      se_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_mon();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    dv_q.delete();
  endtask

  // Holds one bit for Prescale cycles; glitch flips the mid sample only.
  task automatic send_bit(input logic b, input logic glitch);
    for (int i = 0; i < int'(Prescale); i++) begin
      RX_IN = (glitch && i == int'(Prescale) / 2) ? ~b : b;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                            input logic stop_bit, input logic glitch);
    start_cyc = cyc + 1;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    if (has_par) send_bit(par_bit, 1'b0);
    send_bit(stop_bit, 1'b0);
    RX_IN = 1'b1;
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_mon();
    idle(3);
    check("rst_pdata", 32'(P_DATA), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_par_err", 32'(par_err), 32'h0);
    check("rst_stp_err", 32'(stp_err), 32'h0);
    RST = 1'b0;
    idle(3);

    // P=8, no parity, 0xA5
    clear_mon();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("a5_dv_cnt", 32'(dv_cnt), 32'd1);
    check("a5_data", 32'(dv_q.size() > 0 ? dv_q[0] : 8'hxx), 32'hA5);
    check("a5_latency", dv_cyc - start_cyc, 32'd79);
    check("a5_errs", 32'(pe_cnt + se_cnt), 32'd0);
    check("a5_pdata_hold", 32'(P_DATA), 32'hA5);

    // P=16, even parity, 0x3C with correct parity bit 0
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("3c_dv_cnt", 32'(dv_cnt), 32'd1);
    check("3c_data", 32'(P_DATA), 32'h3C);
    check("3c_latency", dv_cyc - start_cyc, 32'd171);
    check("3c_par_err", 32'(pe_cnt), 32'd0);

    // Same frame, wrong parity bit
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("3c_bad_par_err", 32'(pe_cnt), 32'd1);
    check("3c_bad_dv_cnt", 32'(dv_cnt), 32'd0);
    check("3c_bad_stp_err", 32'(se_cnt), 32'd0);
    check("3c_bad_pdata", 32'(P_DATA), 32'h3C);

    // P=32, odd parity, 0xFF (parity bit 1), stop forced low
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_mon();
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(40);
    check("ff_stp_err", 32'(se_cnt), 32'd1);
    check("ff_par_err", 32'(pe_cnt), 32'd0);
    check("ff_dv_cnt", 32'(dv_cnt), 32'd0);
    check("ff_err_latency", err_cyc - start_cyc, 32'd339);
    check("ff_pdata", 32'(P_DATA), 32'h3C);

    // Start glitch at P=8, then a noisy-but-recoverable 0x5A
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_mon();
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(20);
    check("glitch_pulses", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    check("5a_dv_cnt", 32'(dv_cnt), 32'd1);
    check("5a_data", 32'(P_DATA), 32'h5A);
    check("5a_latency", dv_cyc - start_cyc, 32'd79);

    // Back-to-back frames
    clear_mon();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("b2b_dv_cnt", 32'(dv_cnt), 32'd2);
    check("b2b_first", 32'(dv_q.size() > 0 ? dv_q[0] : 8'hxx), 32'h01);
    check("b2b_second", 32'(dv_q.size() > 1 ? dv_q[1] : 8'hxx), 32'h80);
    check("b2b_errs", 32'(pe_cnt + se_cnt), 32'd0);

    // Reset in the middle of the data bits of 0xC3
    clear_mon();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check("midrst_pdata", 32'(P_DATA), 32'h0);
    check("midrst_flags", 32'({data_valid, par_err, stp_err}), 32'h0);
    RX_IN = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(20);
    check("midrst_no_pulse", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("c3_dv_cnt", 32'(dv_cnt), 32'd1);
    check("c3_data", 32'(P_DATA), 32'hC3);
    check("c3_latency", dv_cyc - start_cyc, 32'd79);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the UART TX serializer path.
- Oversamples a pre-synchronized serial line RX_IN by a runtime prescale and recovers start, data, optional parity and stop bits.
- Presents the recovered word in parallel with a one-cycle valid pulse and one-cycle error flags.
- Sits between the RX pin synchronizer and the register-file/command FSM in the UART clock domain.

Parameters:
- DATA_WIDTH, 8, data bits per frame; LSB first on the line.
- PRESCALE_WIDTH, 6, width of Prescale input.

Ports:
- CLK  input  1  UART oversampling clock.
- RST  input  1  asynchronous reset, active-high.
- RX_IN  input  1  serial line, idle high, already synchronized to CLK.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- par_err  output  1  one-cycle pulse on parity mismatch.
- stp_err  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset: FSM=IDLE; counters 0; P_DATA=0; data_valid=par_err=stp_err=0; shift register 0. Reset mid-frame aborts the frame; no output pulse.
- Prescale, PAR_EN and PAR_TYP are latched on frame start and held constant for the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Edge counter: edge_cnt counts 0..P-1 per bit, where P is the latched Prescale.
  - In IDLE, the cycle RX_IN=0 is seen is edge 0 of the start bit; FSM moves to START.
  - edge_cnt wraps to 0 after P-1; each wrap advances to the next bit.
- Sampling:
  - RX_IN is sampled at edges P/2-1, P/2 and P/2+1.
  - The majority of the three samples is registered at edge P/2+2 and forms the bit value.
- START: at edge P/2+2, a sampled 1 is a glitch; FSM returns to IDLE with no outputs. A sampled 0 continues; at edge P-1, go to DATA.
- DATA:
  - Each sampled bit shifts into the MSB of the shift register, shifting right, so the first bit lands at bit 0 after DATA_WIDTH bits.
  - bit_cnt counts 0..DATA_WIDTH-1.
  - After the last bit's edge P-1, go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - Expected value = XOR of the data bits, inverted when PAR_TYP=1.
  - Mismatch is recorded internally; at edge P-1, go to STOP.
- STOP: at edge P/2+2, evaluate the stop sample and recorded parity, then return to IDLE in the next cycle (mid-stop resync allows back-to-back frames). Outputs are registered and high for exactly one cycle after evaluation:
  - stop=1, no parity error: P_DATA<=shift register, data_valid=1.
  - stop=0: stp_err=1; P_DATA unchanged; data_valid=0.
  - parity error: par_err=1; P_DATA unchanged; data_valid=0. Both error flags may pulse together.
- Latency, from the start-bit edge-0 cycle to the data_valid cycle:
  - P=8, no parity: 79 cycles.
  - P=8, with parity: 87 cycles.
  - General formula: (1+DATA_WIDTH+PAR_EN)*P + P/2 + 3.
- In IDLE, RX_IN held low (break) re-triggers a frame each time it is seen low. A break frame produces stp_err, since data=0 and stop=0.

Decomposition:
- uart_pkg holds:
  - rx state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN/PAR_ODD constants;
  - sample-point offset constants.
- One sub-module: rx_data_sampler, containing the 3-sample majority vote and the registered bit output at edge P/2+2.
- The FSM, edge/bit counters, deserializer shift register and parity/stop checking stay in uart_rx.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 -> data_valid pulse at cycle 79 after start edge, P_DATA=0xA5, no errors.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 -> P_DATA=0x3C, par_err=0; same frame with parity 1 -> par_err pulse, data_valid=0, P_DATA unchanged.
- P=32, PAR_TYP=1, 0xFF with stop bit forced 0 -> stp_err pulse only, P_DATA unchanged.
- Start glitch: RX_IN low for 2 cycles at P=8 -> FSM returns to IDLE, no pulses; a following valid 0x5A frame is received correctly.
- Back-to-back frames 0x01 then 0x80 at P=8, the second start bit immediately after the stop bit -> two data_valid pulses, values 0x01 and 0x80.
- RST asserted mid-DATA -> all outputs 0 immediately; a new 0xC3 frame after release is received correctly.
